// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with selectable read mode, occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo_prog #(
    parameter int datawidth  = 8,
    parameter int addr_width = 3,
    parameter int rd_mode    = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [datawidth-1:0]  wdata,
    input  logic                  winc,
    input  logic                  rinc,
    input  logic                  clr_err,
    input  logic [addr_width:0]   afull_thr,
    input  logic [addr_width:0]   aempty_thr,
    output logic [datawidth-1:0]  rdata,
    output logic                  rvalid,
    output logic                  wfull,
    output logic                  rempty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [addr_width:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << addr_width;
    localparam logic [addr_width:0] PTR_ONE = {{addr_width{1'b0}}, 1'b1};

    logic [addr_width:0]  r_wptr;
    logic [addr_width:0]  r_rptr;
    logic [datawidth-1:0] r_mem [DEPTH];
    logic                 r_overflow;
    logic                 r_underflow;

    logic [addr_width:0]  w_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_wr_acc;
    logic                 w_rd_acc;
    logic [datawidth-1:0] w_head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_count  = r_wptr - r_rptr;
    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr == {~r_rptr[addr_width], r_rptr[addr_width-1:0]});
    assign w_wr_acc = winc & ~w_full;
    assign w_rd_acc = rinc & ~w_empty;
    assign w_head   = r_mem[r_rptr[addr_width-1:0]];

    assign count        = w_count;
    assign wfull        = w_full;
    assign rempty       = w_empty;
    assign almost_full  = (w_count >= afull_thr);
    assign almost_empty = (w_count <= aempty_thr);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Write and read pointer advance on accepted requests.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr <= {(addr_width+1){1'b0}};
            r_rptr <= {(addr_width+1){1'b0}};
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

    // Storage array; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr[addr_width-1:0]] <= wdata;
        end
    end

    // Sticky error flags: a new error in the same cycle beats the clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (winc && w_full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rinc && w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (rd_mode == 0) begin : g_registered
            logic [datawidth-1:0] r_rdata;
            logic                 r_rvalid;

            // Registered read: data lands one cycle after the accepted request.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_rdata  <= {datawidth{1'b0}};
                    r_rvalid <= 1'b0;
                end else begin
                    r_rvalid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rdata <= w_head;
                    end
                end
            end

            assign rdata  = r_rdata;
            assign rvalid = r_rvalid;
        end else begin : g_show_ahead
            assign rdata  = w_empty ? {datawidth{1'b0}} : w_head;
            assign rvalid = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: both read modes driven in parallel from one
// stimulus stream and checked against a queue-based reference model.
module tb_sync_fifo_prog;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] wdata;
    logic       winc, rinc, clr_err;
    logic [3:0] afull_thr, aempty_thr;

    logic [7:0] rdata0, rdata1;
    logic       rvalid0, rvalid1, wfull0, wfull1, rempty0, rempty1;
    logic       afull0, afull1, aempty0, aempty1;
    logic [3:0] count0, count1;
    logic       ovf0, ovf1, unf0, unf1;

    int errors = 0;
    int checks = 0;

    // reference model
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    logic       m_rv  = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_prog #(.datawidth(8), .addr_width(3), .rd_mode(0)) dut0 (
        .clk(clk), .rstn(rstn), .wdata(wdata), .winc(winc), .rinc(rinc),
        .clr_err(clr_err), .afull_thr(afull_thr), .aempty_thr(aempty_thr),
        .rdata(rdata0), .rvalid(rvalid0), .wfull(wfull0), .rempty(rempty0),
        .almost_full(afull0), .almost_empty(aempty0), .count(count0),
        .overflow(ovf0), .underflow(unf0));

    sync_fifo_prog #(.datawidth(8), .addr_width(3), .rd_mode(1)) dut1 (
        .clk(clk), .rstn(rstn), .wdata(wdata), .winc(winc), .rinc(rinc),
        .clr_err(clr_err), .afull_thr(afull_thr), .aempty_thr(aempty_thr),
        .rdata(rdata1), .rvalid(rvalid1), .wfull(wfull1), .rempty(rempty1),
        .almost_full(afull1), .almost_empty(aempty1), .count(count1),
        .overflow(ovf1), .underflow(unf1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_rv  = 1'b0;
    endtask

    // One clock of FIFO semantics computed from the queue, before the edge.
    task automatic model_step(input logic w, input logic [7:0] d, input logic r, input logic c);
        bit full, empty, wa, ra;
        full  = (mq.size() == 8);
        empty = (mq.size() == 0);
        wa = w && !full;
        ra = r && !empty;
        if (ra) exp_q.push_back(mq.pop_front());
        if (wa) mq.push_back(d);
        if (w && full) m_ovf = 1'b1;
        else if (c)    m_ovf = 1'b0;
        if (r && empty) m_unf = 1'b1;
        else if (c)     m_unf = 1'b0;
        m_rv = ra;
    endtask

    task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic c);
        winc = w; wdata = d; rinc = r; clr_err = c;
        model_step(w, d, r, c);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_flags_now(input string tag);
        int n;
        n = mq.size();
        chk({tag, "_count0"}, 32'(count0), 32'(n));
        chk({tag, "_count1"}, 32'(count1), 32'(n));
        chk({tag, "_rempty"}, 32'(rempty0), 32'(n == 0));
        chk({tag, "_wfull"},  32'(wfull0),  32'(n == 8));
        chk({tag, "_afull"},  32'(afull0),  32'(n >= int'(afull_thr)));
        chk({tag, "_afull1"}, 32'(afull1),  32'(n >= int'(afull_thr)));
        chk({tag, "_aempty"}, 32'(aempty0), 32'(n <= int'(aempty_thr)));
    endtask

    // Monitor: compares every output shortly after each rising edge.
    initial begin
        logic [7:0] head;
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            chk_flags_now("mon");
            chk("mon_wfull1",  32'(wfull1),  32'(mq.size() == 8));
            chk("mon_rempty1", 32'(rempty1), 32'(mq.size() == 0));
            chk("mon_aempty1", 32'(aempty1), 32'(mq.size() <= int'(aempty_thr)));
            chk("mon_ovf0", 32'(ovf0), 32'(m_ovf));
            chk("mon_ovf1", 32'(ovf1), 32'(m_ovf));
            chk("mon_unf0", 32'(unf0), 32'(m_unf));
            chk("mon_unf1", 32'(unf1), 32'(m_unf));
            chk("mon_rvalid0", 32'(rvalid0), 32'(m_rv));
            chk("mon_rvalid1", 32'(rvalid1), 32'd0);
            head = (mq.size() == 0) ? 8'h00 : mq[0];
            chk("mon_rdata1", 32'(rdata1), 32'(head));
            if (rvalid0 === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_rdata0", 32'(rdata0), 32'(e));
                end
            end
        end
    end

    initial begin
        rstn = 1'b0; winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; wdata = 8'h00;
        afull_thr = 4'd8; aempty_thr = 4'd0;
        model_reset();
        #3;
        chk("rst_count", 32'(count0), 32'd0);
        chk("rst_rempty", 32'(rempty0), 32'd1);
        chk("rst_rdata0", 32'(rdata0), 32'd0);
        chk("rst_rvalid0", 32'(rvalid0), 32'd0);
        chk("rst_aempty", 32'(aempty0), 32'd1);
        chk("rst_afull", 32'(afull0), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // fill with 0x11..0x88, overflow, clear, drain, underflow
        for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i * 17), 1'b0, 1'b0);
        chk("fill_wfull", 32'(wfull0), 32'd1);
        chk("fill_count", 32'(count0), 32'd8);
        cycle(1'b1, 8'h99, 1'b0, 1'b0);
        chk("ovf_set", 32'(ovf0), 32'd1);
        chk("ovf_count", 32'(count0), 32'd8);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", 32'(ovf0), 32'd0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_rempty", 32'(rempty0), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("unf_set", 32'(unf0), 32'd1);
        chk("unf_rvalid", 32'(rvalid0), 32'd0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // half full streaming across the pointer wrap
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        for (int i = 4; i < 24; i++) cycle(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
        chk("stream_count", 32'(count0), 32'd4);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // programmable thresholds, including a same-cycle threshold change
        afull_thr = 4'd6; aempty_thr = 4'd2;
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        chk("thr_afull6", 32'(afull0), 32'd1);
        afull_thr = 4'd7;
        #1;
        chk("thr_afull7_now", 32'(afull0), 32'd0);
        chk("thr_afull7_now1", 32'(afull1), 32'd0);
        afull_thr = 4'd6;
        for (int i = 6; i < 8; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        afull_thr = 4'd0;
        #1;
        chk("thr_zero_afull", 32'(afull0), 32'd1);
        afull_thr = 4'd8; aempty_thr = 4'd0;

        // show-ahead head word
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("sa_head", 32'(rdata1), 32'hA5);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("sa_pop_rdata", 32'(rdata1), 32'h00);
        chk("sa_pop_rempty", 32'(rempty1), 32'd1);

        // asynchronous reset in the middle of operation
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        winc = 1'b0; rinc = 1'b0;
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        chk("arst_count", 32'(count0), 32'd0);
        chk("arst_rempty", 32'(rempty0), 32'd1);
        chk("arst_rdata1", 32'(rdata1), 32'd0);
        chk("arst_rdata0", 32'(rdata0), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        cycle(1'b1, 8'h78, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("arst_first_read", 32'(rdata0), 32'h77);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // randomized traffic with drifting bias and thresholds
        for (int i = 0; i < 400; i++) begin
            int bias;
            bias = ((i / 50) % 2 == 0) ? 70 : 30;
            if ($urandom_range(9, 0) == 0) begin
                afull_thr  = 4'($urandom_range(8, 0));
                aempty_thr = 4'($urandom_range(8, 0));
            end
            cycle(1'($urandom_range(99, 0) < bias), 8'($urandom),
                  1'($urandom_range(99, 0) < (100 - bias)),
                  1'($urandom_range(9, 0) == 0));
        end

        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
